// File: rtl/serial_const_adder_if.sv
// rtl/serial_const_adder_if.sv - serial data and parallel result bundle for serial_const_adder
//
// Purpose: groups the serial input, serial output and parallel result signals.
// Ports (signals):
//   X      master->slave  serial data bit, LSB of each word first
//   X_EN   master->slave  X holds a valid bit this cycle
//   SYNC   master->slave  synchronous word restart
//   D      slave->master  serial sum bit (Mealy)
//   C      slave->master  carry-out of word, only on the accepted last bit
//   LAST   slave->master  current bit index is WIDTH-1 (Moore)
//   Q      slave->master  parallel sum of last completed word
//   Q_VLD  slave->master  one-cycle pulse when Q/Q_OVF update
//   Q_OVF  slave->master  carry-out of the word held in Q
// Modports: master (data source / result consumer), slave (the adder).
interface serial_const_adder_if #(
  parameter int WIDTH = 4
);
  logic             X;
  logic             X_EN;
  logic             SYNC;
  logic             D;
  logic             C;
  logic             LAST;
  logic [WIDTH-1:0] Q;
  logic             Q_VLD;
  logic             Q_OVF;

  modport master (
    output X, X_EN, SYNC,
    input  D, C, LAST, Q, Q_VLD, Q_OVF
  );

  modport slave (
    input  X, X_EN, SYNC,
    output D, C, LAST, Q, Q_VLD, Q_OVF
  );
endinterface

// File: rtl/serial_const_adder.sv
// rtl/serial_const_adder.sv - bit-serial LSB-first adder of a constant to each word
//
// Purpose: adds ADDEND (mod 2^WIDTH) to every WIDTH-bit word arriving LSB first
//   on X. Sum bits leave combinationally on D; the word carry leaves on C with
//   the last bit. The completed sum is also collected into Q with a one-cycle
//   Q_VLD pulse and its carry in Q_OVF.
// Parameters: WIDTH (2..16) bits per word, ADDEND constant added per word.
// Ports:
//   CLK  in  clock, rising edge
//   CLR  in  reset, asynchronous, active-low
//   bus  serial_const_adder_if.slave (X, X_EN, SYNC in; D, C, LAST, Q, Q_VLD, Q_OVF out)
module serial_const_adder #(
  parameter int WIDTH  = 4,
  parameter int ADDEND = 2
) (
  input  logic                  CLK,
  input  logic                  CLR,
  serial_const_adder_if.slave   bus
);

  localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0]  IDX_LAST = IDXW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ADD_W    = ADDEND[WIDTH-1:0];

  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-2:0] shift;
  logic [WIDTH-1:0] q;
  logic             q_vld;
  logic             q_ovf;

  logic             last_bit;
  logic             accept;
  logic [1:0]       sum;
  logic [WIDTH-2:0] shift_nxt;

  assign last_bit = (idx == IDX_LAST);
  // SYNC wins over X_EN: the bit on X during a restart is discarded.
  assign accept   = bus.X_EN && !bus.SYNC;
  assign sum      = {1'b0, bus.X} + {1'b0, ADD_W[idx]} + {1'b0, carry};

  // Sum bits enter at the top and move down, so after WIDTH-1 bits the first
  // bit of the word sits at shift[0].
  if (WIDTH == 2) begin : g_shift_w2
    assign shift_nxt = sum[0];
  end else begin : g_shift_wn
    assign shift_nxt = {sum[0], shift[WIDTH-2:1]};
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      idx   <= '0;
      carry <= 1'b0;
      shift <= '0;
      q     <= '0;
      q_vld <= 1'b0;
      q_ovf <= 1'b0;
    end else begin
      q_vld <= 1'b0;
      if (bus.SYNC) begin
        idx   <= '0;
        carry <= 1'b0;
        shift <= '0;
      end else if (bus.X_EN) begin
        if (last_bit) begin
          idx   <= '0;
          carry <= 1'b0;
          q     <= {sum[0], shift};
          q_ovf <= sum[1];
          q_vld <= 1'b1;
        end else begin
          idx   <= idx + IDXW'(1);
          carry <= sum[1];
          shift <= shift_nxt;
        end
      end
    end
  end

  // Mealy outputs are gated by reset and acceptance so idle or discarded
  // cycles always show zero.
  assign bus.D     = CLR && accept && sum[0];
  assign bus.C     = CLR && accept && last_bit && sum[1];
  assign bus.LAST  = CLR && last_bit;
  assign bus.Q     = q;
  assign bus.Q_VLD = q_vld;
  assign bus.Q_OVF = q_ovf;

  // Unknown control or accepted data must never reach the state registers.
  always @(posedge CLK) begin
    if (CLR) begin
      assert (!$isunknown({bus.SYNC, bus.X_EN}));
      if (bus.X_EN && !bus.SYNC) assert (!$isunknown(bus.X));
    end
  end

endmodule
